ibex_fetch_req_ctrl: RTL

//  Sequences instruction-memory requests on behalf of the IF stage and feeds the fetch FIFO.
//  - Issues word-aligned fetches on an OBI-style req/gnt/rvalid bus.
//  - Bounds requests in flight to NUM_REQS, throttled by FIFO occupancy.
//  - On a branch: clears the FIFO and discards stale responses.

---
 rtl/ibex_pkg.sv | 11 +
 rtl/ibex_fetch_req_tracker.sv | 71 +++++++
 rtl/ibex_fetch_req_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared fetch-path constants and types
package ibex_pkg;

    localparam logic [31:0] FETCH_ADDR_INCR = 32'd4;

    typedef struct packed {
        logic out;
        logic discard;
    } fetch_track_t;

endpackage

// File: rtl/ibex_fetch_req_tracker.sv
// rtl/ibex_fetch_req_tracker.sv - in-order outstanding/discard shift vector for fetch requests
module ibex_fetch_req_tracker
    import ibex_pkg::*;
#(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                gnt_i,
    input  logic                gnt_discard_i,
    input  logic                rvalid_i,
    input  logic                branch_i,
    output logic [NUM_REQS-1:0] out_o,
    output logic                oldest_discard_o
);

    fetch_track_t [NUM_REQS-1:0] track_q;
    fetch_track_t [NUM_REQS-1:0] track_s;
    fetch_track_t [NUM_REQS-1:0] track_d;
    logic                        rvalid_pop;
    logic                        placed;

    // A response with nothing outstanding is ignored rather than corrupting the vector.
    assign rvalid_pop = rvalid_i & track_q[0].out;

    always_comb begin
        track_s = track_q;
        if (rvalid_pop) begin
            for (int i = 0; i < NUM_REQS - 1; i++) begin
                track_s[i] = track_q[i+1];
            end
            track_s[NUM_REQS-1] = '0;
        end
        if (branch_i) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                track_s[i].discard = track_s[i].discard | track_s[i].out;
            end
        end

        // New grant lands after the shift so both can happen in one cycle.
        track_d = track_s;
        placed  = 1'b0;
        if (gnt_i) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!placed && !track_s[i].out) begin
                    track_d[i].out     = 1'b1;
                    track_d[i].discard = gnt_discard_i;
                    placed             = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            track_q <= '0;
        end else begin
            track_q <= track_d;
        end
    end

    always_comb begin
        out_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            out_o[i] = track_q[i].out;
        end
    end

    assign oldest_discard_o = track_q[0].discard;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - instruction-bus fetch request sequencer feeding the fetch FIFO
module ibex_fetch_req_ctrl
    import ibex_pkg::*;
#(
    parameter int NUM_REQS = 2,
    parameter bit ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    output logic [31:0]         fifo_addr_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i
);

    logic [NUM_REQS-1:0] out_q;
    logic [NUM_REQS-1:0] out_rev;
    logic                oldest_discard;
    logic                fifo_ready;
    logic                issue_new;
    logic                gnt;
    logic                gnt_discard;
    logic                pend_q;
    logic                pend_discard_q;
    logic [31:0]         branch_target;
    logic [31:0]         fetch_addr_q;
    logic [31:0]         fetch_addr_d;
    logic [31:0]         pend_addr_q;

    ibex_fetch_req_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_tracker (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .gnt_i            (gnt),
        .gnt_discard_i    (gnt_discard),
        .rvalid_i         (instr_rvalid_i),
        .branch_i         (branch_i),
        .out_o            (out_q),
        .oldest_discard_o (oldest_discard)
    );

    assign branch_target = {branch_addr_i[31:2], 2'b00};

    always_comb begin
        out_rev = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            out_rev[i] = out_q[NUM_REQS-1-i];
        end
    end

    assign fifo_ready   = ~&(fifo_busy_i | out_rev);
    assign issue_new    = req_i & (fifo_ready | branch_i) & ~out_q[NUM_REQS-1];
    assign instr_req_o  = pend_q | issue_new;
    assign instr_addr_o = pend_q ? pend_addr_q : (branch_i ? branch_target : fetch_addr_q);
    assign gnt          = instr_req_o & instr_gnt_i;
    assign gnt_discard  = pend_q & (pend_discard_q | branch_i);

    // fetch_addr_q doubles as the latched branch target while a stale request is held.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = (gnt & ~pend_q) ? branch_target + FETCH_ADDR_INCR : branch_target;
        end else if (gnt & ~gnt_discard) begin
            fetch_addr_d = instr_addr_o + FETCH_ADDR_INCR;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q         <= 1'b0;
            pend_discard_q <= 1'b0;
            fetch_addr_q   <= '0;
        end else begin
            pend_q         <= instr_req_o & ~instr_gnt_i;
            pend_discard_q <= instr_req_o & ~instr_gnt_i & gnt_discard;
            fetch_addr_q   <= fetch_addr_d;
        end
    end

    if (ResetAll) begin : g_pend_addr_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                pend_addr_q <= '0;
            end else if (instr_req_o & ~pend_q) begin
                pend_addr_q <= instr_addr_o;
            end
        end
    end else begin : g_pend_addr_nrst
        always_ff @(posedge clk_i) begin
            if (instr_req_o & ~pend_q) begin
                pend_addr_q <= instr_addr_o;
            end
        end
    end

    assign busy_o       = |out_q | pend_q;
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_valid_o = instr_rvalid_i & out_q[0] & ~oldest_discard & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    fifo_full_no_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_valid_o && fifo_busy_i[NUM_REQS-1]));

endmodule
